// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP/OP-IMM instructions into ALU operands behind a valid/ready register slice.
// Define ISSUE_SKID_BUF_EN to add a one-entry skid buffer so in_ready depends only on stored state.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } issue_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  issue_t     dec;
  logic       unused_rs1_field;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign unused_rs1_field = ^in_inst[19:15];

  always_comb begin
    legal   = 1'b0;
    dec.a   = in_rs1_data;
    dec.rd  = in_inst[11:7];
    dec.b   = '0;
    dec.op  = 4'b0000;
    dec.ill = 1'b1;
    case (opcode)
      OPC_OP: begin
        legal = ((funct7 == F7_ZERO) && (funct3 != 3'b010) && (funct3 != 3'b011)) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        if (legal) begin
          dec.op  = {in_inst[30], funct3};
          dec.b   = in_rs2_data;
          dec.ill = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b010, 3'b011: legal = 1'b0;
          3'b001:         legal = (funct7 == F7_ZERO);
          3'b101:         legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          default:        legal = 1'b1;
        endcase
        // Only shifts use inst[30] as an opcode bit; ADDI with imm[10]=1 must stay ADD.
        if (legal) begin
          dec.op  = (funct3 == 3'b101) ? {in_inst[30], 3'b101} : {1'b0, funct3};
          dec.b   = {{20{in_inst[31]}}, in_inst[31:20]};
          dec.ill = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  issue_t out_reg;
  logic   out_valid_reg;
  logic   accept;
  logic   out_fire;

  assign accept   = in_valid && in_ready && !flush;
  assign out_fire = out_valid_reg && out_ready;

`ifdef ISSUE_SKID_BUF_EN
  issue_t skid_reg;
  logic   skid_valid_reg;

  assign in_ready = !rst && !skid_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      skid_valid_reg <= 1'b0;
      skid_reg       <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      // in_ready is low here, so the only move is skid -> output on a transfer.
      if (out_fire) begin
        out_reg        <= skid_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (out_valid_reg && !out_ready) begin
        skid_reg       <= dec;
        skid_valid_reg <= 1'b1;
      end else begin
        out_reg       <= dec;
        out_valid_reg <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
    end
  end
`else
  assign in_ready = !rst && (!out_valid_reg || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_reg       <= dec;
      out_valid_reg <= 1'b1;
    end else if (out_fire) begin
      out_valid_reg <= 1'b0;
    end
  end
`endif

  assign out_valid   = out_valid_reg;
  assign out_a       = out_reg.a;
  assign out_b       = out_reg.b;
  assign out_alu_op  = out_reg.op;
  assign out_rd      = out_reg.rd;
  assign out_illegal = out_reg.ill;

endmodule
